clk_div_monitor: RTL and testbench

- Checker for the half-rate quadrature clock pair produced by the LP clock divider.
- Sits in the full-rate clk_i domain and samples clk0/clk90 as data on every clk_i rising edge.
- Acquires lock once the pair toggles in the legal pattern. Flags stuck or partial-toggle faults, counts errors and exposes lock/fault status to LP control logic.
- Sim/diagnostic block; it does not drive any clock.

---
 rtl/clk_div_mon_pkg.sv | 31 +++
 rtl/clk_div_monitor_if.sv | 32 +++
 rtl/clk_div_mon_classify.sv | 37 +++
 rtl/clk_div_monitor.sv | 190 +++++++++++++++++++
 tb/tb_clk_div_monitor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_mon_pkg
// Shared types and helpers for the quadrature clock-pair monitor.
//   mon_state_e    : monitor FSM states
//   sample_class_e : classification of one {clk0, clk90} sample against the
//                    previous one
//   cnt_width()    : width needed to hold a count of 0..max_val
// -----------------------------------------------------------------------------
package clk_div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    GOOD  = 2'd0,
    STUCK = 2'd1,
    HALF  = 2'd2
  } sample_class_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int LOCK_CNT_DEF = 8;
  localparam int GOOD_CNT_W   = $clog2(LOCK_CNT_DEF + 1);

endpackage

// File: rtl/clk_div_monitor_if.sv
// -----------------------------------------------------------------------------
// clk_div_monitor_if
// Bundles the observed divider signals and the monitor status outputs.
//   clk0_i, clk90_i : divided quadrature pair, sampled as data
//   div_rst_i       : divider released (high = running)
//   locked_o        : pair toggling legally
//   fault_o         : sticky fault
//   phase_o         : clk0^clk90 captured at lock
//   err_cnt_o       : saturating bad-sample count
// Modports: master = divider side / stimulus, slave = the monitor.
// -----------------------------------------------------------------------------
interface clk_div_monitor_if #(
  parameter int ERR_W = 8
);
  logic             clk0_i;
  logic             clk90_i;
  logic             div_rst_i;
  logic             locked_o;
  logic             fault_o;
  logic             phase_o;
  logic [ERR_W-1:0] err_cnt_o;

  modport master (
    output clk0_i, clk90_i, div_rst_i,
    input  locked_o, fault_o, phase_o, err_cnt_o
  );

  modport slave (
    input  clk0_i, clk90_i, div_rst_i,
    output locked_o, fault_o, phase_o, err_cnt_o
  );
endinterface

// File: rtl/clk_div_mon_classify.sv
// -----------------------------------------------------------------------------
// clk_div_mon_classify
// Holds the previous sample p and classifies the current sample s:
//   GOOD  : both bits toggled (s == ~p)
//   STUCK : no bit toggled    (s == p)
//   HALF  : exactly one bit toggled
// Ports:
//   clk_i   : full-rate clock
//   rst_i   : synchronous active-high reset (p -> 2'b00)
//   s_i     : current {clk0, clk90} sample
//   class_o : classification of s_i against p
// -----------------------------------------------------------------------------
module clk_div_mon_classify
  import clk_div_mon_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    s_i,
  output sample_class_e class_o
);

  logic [1:0] p_q;

  // p tracks every sample, including the one seen on ACQUIRE entry, so the
  // first classified sample in ACQUIRE is compared against real data.
  always_ff @(posedge clk_i) begin
    if (rst_i) p_q <= 2'b00;
    else       p_q <= s_i;
  end

  always_comb begin
    class_o = HALF;
    if (s_i == ~p_q)      class_o = GOOD;
    else if (s_i == p_q)  class_o = STUCK;
  end

endmodule

// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
// Checks the half-rate quadrature pair from the LP clock divider by sampling
// it as data in the full-rate domain. Acquires lock on LOCK_CNT consecutive
// legal toggles, declares a sticky fault after LOSS_CNT consecutive bad
// samples while locked, and keeps a saturating error count.
// Ports:
//   clk_i : full-rate clock
//   rst_i : synchronous active-high reset
//   mon   : clk_div_monitor_if.slave (pair in, div_rst_i in, status out)
// Optional build macro CLK_DIV_MON_TIMEOUT_EN: adds an ACQUIRE timer that
// faults after TIMEOUT cycles without lock (counted once in err_cnt).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | divider held in reset; waiting for div_rst_i
// ACQUIRE | counting consecutive good samples toward LOCK_CNT
// LOCKED  | pair legal; counting bad runs toward LOSS_CNT
// FAULT   | sticky fault until div_rst_i low or rst_i
// -----------------------------------------------------------------------------
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  clk_div_monitor_if.slave  mon
);

  localparam int GOOD_W = (LOCK_CNT == LOCK_CNT_DEF) ? GOOD_CNT_W : cnt_width(LOCK_CNT);
  localparam int BAD_W  = cnt_width(LOSS_CNT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CNT - 1);

  if (LOCK_CNT < 1 || LOCK_CNT > 255 || LOSS_CNT < 1 || LOSS_CNT > 15 ||
      ERR_W < 1 || TIMEOUT < 1) begin : g_param_check
    $error("clk_div_monitor: parameter out of range");
  end

  logic [1:0]    s;
  sample_class_e cls;
  logic          is_good;

  assign s       = {mon.clk0_i, mon.clk90_i};
  assign is_good = (cls == GOOD);

  clk_div_mon_classify u_classify (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .s_i     (s),
    .class_o (cls)
  );

  mon_state_e        state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              locked_q, locked_d;
  logic              fault_q, fault_d;
  logic              phase_q, phase_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              err_inc;

`ifdef CLK_DIV_MON_TIMEOUT_EN
  localparam int TMR_W = cnt_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      phase_q  <= 1'b0;
      err_q    <= '0;
`ifdef CLK_DIV_MON_TIMEOUT_EN
      tmr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      phase_q  <= phase_d;
      err_q    <= err_d;
`ifdef CLK_DIV_MON_TIMEOUT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    locked_d = locked_q;
    fault_d  = fault_q;
    phase_d  = phase_q;
    err_inc  = 1'b0;
`ifdef CLK_DIV_MON_TIMEOUT_EN
    tmr_d    = tmr_q;
`endif

    if (!mon.div_rst_i) begin
      // Divider back in reset: drop status but keep err_cnt history.
      state_d  = IDLE;
      good_d   = '0;
      bad_d    = '0;
      locked_d = 1'b0;
      fault_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // This cycle's sample only seeds p; classification starts next cycle.
          state_d = ACQUIRE;
          good_d  = '0;
          bad_d   = '0;
`ifdef CLK_DIV_MON_TIMEOUT_EN
          tmr_d   = TMR_LOAD;
`endif
        end

        ACQUIRE: begin
          if (is_good) begin
            if (good_q == GOOD_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              phase_d  = s[1] ^ s[0];
              good_d   = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            good_d = '0;
          end
`ifdef CLK_DIV_MON_TIMEOUT_EN
          // Locking on the final timer cycle wins over the timeout.
          if (state_d == ACQUIRE) begin
            if (tmr_q == '0) begin
              state_d = FAULT;
              fault_d = 1'b1;
              err_inc = 1'b1;
            end else begin
              tmr_d = tmr_q - 1'b1;
            end
          end
`endif
        end

        LOCKED: begin
          if (is_good) begin
            bad_d = '0;
          end else begin
            err_inc = 1'b1;
            if (bad_q == BAD_LAST) begin
              state_d  = FAULT;
              locked_d = 1'b0;
              fault_d  = 1'b1;
              bad_d    = '0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end
        end

        FAULT: begin
          // Keep counting bad samples so err_cnt reflects the full fault.
          if (!is_good) err_inc = 1'b1;
        end

        default: state_d = IDLE;
      endcase
    end

    err_d = (err_inc && (err_q != {ERR_W{1'b1}})) ? err_q + 1'b1 : err_q;
  end

  assign mon.locked_o  = locked_q;
  assign mon.fault_o   = fault_q;
  assign mon.phase_o   = phase_q;
  assign mon.err_cnt_o = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_div_monitor
// Scoreboard bench: each driven sample advances an independent reference model
// whose expected outputs are queued and compared one edge later.
// -----------------------------------------------------------------------------
module tb_clk_div_monitor;

  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 2;
  localparam int ERR_W    = 8;
  localparam int TIMEOUT  = 64;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  clk_div_monitor_if #(.ERR_W(ERR_W)) mon_if ();

  clk_div_monitor #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .ERR_W    (ERR_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .mon   (mon_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic locked;
    logic fault;
    logic phase;
    int   err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  int         m_state = M_IDLE;
  int         m_good = 0, m_bad = 0, m_err = 0, m_elapsed = 0;
  logic [1:0] m_p = 2'b00;
  logic       m_locked = 0, m_fault = 0, m_phase = 0;
  logic [1:0] cur = 2'b00;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("sb_locked", int'(mon_if.locked_o), int'(e.locked));
      check_eq("sb_fault",  int'(mon_if.fault_o),  int'(e.fault));
      check_eq("sb_phase",  int'(mon_if.phase_o),  int'(e.phase));
      check_eq("sb_err",    int'(mon_if.err_cnt_o), e.err);
    end
  end

  function automatic int sat_inc(input int v);
    return (v < ERR_MAX) ? v + 1 : v;
  endfunction

  // Drive one sample before the edge, advance the model, queue its outputs,
  // then return just after the edge so callers can spot-check outputs.
  task automatic step(input logic [1:0] s, input logic dr, input logic r);
    exp_t e;
    logic good;
    @(negedge clk_i);
    rst_i            = r;
    mon_if.clk0_i    = s[1];
    mon_if.clk90_i   = s[0];
    mon_if.div_rst_i = dr;
    good = (s == ~m_p);
    if (r) begin
      m_state = M_IDLE; m_good = 0; m_bad = 0; m_err = 0;
      m_locked = 0; m_fault = 0; m_phase = 0;
    end else if (!dr) begin
      m_state = M_IDLE; m_good = 0; m_bad = 0; m_locked = 0; m_fault = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          m_state = M_ACQ; m_good = 0; m_bad = 0; m_elapsed = 0;
        end
        M_ACQ: begin
          m_good = good ? m_good + 1 : 0;
          if (m_good == LOCK_CNT) begin
            m_state = M_LOCK; m_locked = 1; m_phase = s[1] ^ s[0]; m_good = 0;
          end
`ifdef CLK_DIV_MON_TIMEOUT_EN
          if (m_state == M_ACQ) begin
            m_elapsed++;
            if (m_elapsed == TIMEOUT) begin
              m_state = M_FAULT; m_fault = 1; m_err = sat_inc(m_err);
            end
          end
`endif
        end
        M_LOCK: begin
          if (good) m_bad = 0;
          else begin
            m_err = sat_inc(m_err);
            m_bad++;
            if (m_bad == LOSS_CNT) begin
              m_state = M_FAULT; m_locked = 0; m_fault = 1; m_bad = 0;
            end
          end
        end
        default: if (!good) m_err = sat_inc(m_err);
      endcase
    end
    m_p = r ? 2'b00 : s;
    cur = s;
    e.locked = m_locked; e.fault = m_fault; e.phase = m_phase; e.err = m_err;
    sb_q.push_back(e);
    @(posedge clk_i);
    #2;
  endtask

  task automatic legal(input int n);
    for (int i = 0; i < n; i++) step(~cur, 1'b1, 1'b0);
  endtask

  task automatic expect_out(input string tag, input int lk, input int ft, input int ph, input int er);
    check_eq({tag, "_locked"}, int'(mon_if.locked_o), lk);
    check_eq({tag, "_fault"},  int'(mon_if.fault_o),  ft);
    check_eq({tag, "_phase"},  int'(mon_if.phase_o),  ph);
    check_eq({tag, "_err"},    int'(mon_if.err_cnt_o), er);
  endtask

  initial begin
    mon_if.clk0_i    = 1'b0;
    mon_if.clk90_i   = 1'b0;
    mon_if.div_rst_i = 1'b0;

    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    expect_out("reset", 0, 0, 0, 0);

    // Acquire with 01,10,01,...: first sample only seeds p.
    step(2'b01, 1'b1, 1'b0);
    legal(LOCK_CNT - 1);
    expect_out("pre_lock", 0, 0, 0, 0);
    legal(1);
    expect_out("lock", 1, 0, 1, 0);

    // Stuck at 10 for two samples while locked.
    legal(1);
    check_eq("cur_is_10", int'(cur), 2);
    step(cur, 1'b1, 1'b0);
    expect_out("stuck1", 1, 0, 1, 1);
    step(cur, 1'b1, 1'b0);
    expect_out("stuck2", 0, 1, 1, 2);
    legal(4);
    expect_out("fault_sticky", 0, 1, 1, 2);

    // div_rst_i low for one cycle clears fault, err retained, re-lock.
    step(cur, 1'b0, 1'b0);
    expect_out("div_rst_low", 0, 0, 1, 2);
    legal(1);
    legal(LOCK_CNT - 1);
    expect_out("relock_pre", 0, 0, 1, 2);
    legal(1);
    expect_out("relock", 1, 0, 1, 2);

    // Single half toggle while locked, then legal resumes.
    step(cur ^ 2'b01, 1'b1, 1'b0);
    expect_out("half", 1, 0, 1, 3);
    legal(3);
    expect_out("half_recover", 1, 0, 1, 3);

    // Saturation.
    for (int i = 0; i < 300; i++) step(cur, 1'b1, 1'b0);
    expect_out("saturate", 0, 1, 1, ERR_MAX);
    step(cur, 1'b1, 1'b1);
    expect_out("reset2", 0, 0, 0, 0);

    // Stuck pair from ACQUIRE entry.
    step(2'b00, 1'b1, 1'b0);
`ifdef CLK_DIV_MON_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT - 1; i++) step(2'b00, 1'b1, 1'b0);
    expect_out("tmo_pre", 0, 0, 0, 0);
    step(2'b00, 1'b1, 1'b0);
    expect_out("tmo_fault", 0, 1, 0, 1);
`else
    for (int i = 0; i < 1000; i++) step(2'b00, 1'b1, 1'b0);
    expect_out("no_tmo", 0, 0, 0, 0);
`endif

    @(negedge clk_i);
    check_eq("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
